// File: rtl/demux16_stream.sv
// demux16_stream: steers each input word to one of 16 lanes, one-entry reg per lane.
// Defining DEMUX16_BCAST_EN adds a bcast input that loads all lanes at once.
module demux16_stream #(
  parameter  int WIDTH = 16,
  parameter  int SEL_W = 4,
  localparam int LANES = 2**SEL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       a,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   in_valid,
`ifdef DEMUX16_BCAST_EN
  input  logic                   bcast,
`endif
  output logic                   in_ready,
  output logic [LANES*WIDTH-1:0] y,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [15:0]            acc_cnt
);

  logic [LANES-1:0] lane_free;
  logic [LANES-1:0] load;
  logic             accept;

  // Lane is writable when empty or being drained this cycle; pick target lanes.
  always_comb begin
    lane_free = ~out_valid | out_ready;
    in_ready  = lane_free[sel];
`ifdef DEMUX16_BCAST_EN
    if (bcast) in_ready = &lane_free;
`endif
    accept = in_valid & in_ready;
    load   = '0;
    for (int i = 0; i < LANES; i++) begin
      load[i] = accept & (sel == SEL_W'(i));
    end
`ifdef DEMUX16_BCAST_EN
    if (bcast) load = {LANES{accept}};
`endif
  end

  // Lane registers, valid flags and accept counter; refill wins over drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      y         <= '0;
      acc_cnt   <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (load[i]) begin
          y[WIDTH*i +: WIDTH] <= a;
          out_valid[i]        <= 1'b1;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
      if (accept) acc_cnt <= acc_cnt + 16'd1;
    end
  end

endmodule

// File: doc/demux16_stream.md
Name: demux16_stream

Overview:
- 1-to-16 demultiplexer: the distribution-side counterpart of the team's 16:1 word mux.
- Steers each 16-bit input word to one of 16 output lanes selected by a 4-bit select.
- Every lane has a one-entry output register with a valid/ready handshake.
- Sits between a single producer and 16 independent consumers; back-pressure from the selected lane stalls the producer.

Parameters:
- WIDTH, 16, data word width per lane.
- SEL_W, 4, select width; lane count LANES = 2**SEL_W = 16 is derived, not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  input data word.
- sel  input  SEL_W  destination lane index, 0..15.
- in_valid  input  1  producer presents a/sel.
- in_ready  output  1  block can accept a/sel this cycle.
- y  output  LANES*WIDTH  lane data, flattened; lane i occupies bits [WIDTH*i +: WIDTH].
- out_valid  output  LANES  per-lane word available.
- out_ready  input  LANES  per-lane consumer accepts.
- acc_cnt  output  16  count of accepted input words.

Behaviour:
- Reset, sampled on the rising edge while rst=1:
  - out_valid=0, all lanes of y=0, acc_cnt=0.
  - in_ready follows the combinational rule below; it reads 1 after reset.
  - Reset mid-operation discards all buffered words without handshaking them out.
- in_ready (combinational) = ~out_valid[sel] | out_ready[sel]. Depends only on sel, lane state and out_ready; never on in_valid.
- accept = in_valid & in_ready. On accept, at the next edge:
  - lane sel register <= a;
  - out_valid[sel] <= 1;
  - acc_cnt increments.
  - Latency: input to lane output is 1 cycle.
- Lane drain: out_valid[i] & out_ready[i] is a transfer.
  - The lane clears out_valid[i] at the next edge unless the same cycle also accepts into lane i.
  - A simultaneous drain and refill leaves out_valid[i]=1 holding the new word: full throughput, one word per cycle into a single lane.
- Non-selected lanes are unaffected by accepts; each drains independently.
- When out_valid[i]=0, lane i of y holds its last value (0 after reset). out_ready[i] has no effect.
- Producer rule: while in_valid=1 and not accepted, a and sel must stay stable. The block does not need to tolerate violations.
- acc_cnt is 16 bits and wraps 0xFFFF -> 0x0000.
- in_ready is computed for the currently presented sel only. A blocked lane stalls the input even if other lanes are free (no reordering).
- No internal FSM beyond the per-lane valid flags; the 16 lane registers plus valid bits form the only state.

Optional Feature:
- Macro: DEMUX16_BCAST_EN.
- Defined:
  - Adds port bcast (input, 1).
  - With in_valid=1 and bcast=1, sel is ignored.
  - in_ready = AND over all i of (~out_valid[i] | out_ready[i]).
  - On accept, all 16 lane registers load a and all out_valid bits set.
  - acc_cnt increments by 1 per broadcast accept.
  - bcast=0 behaves exactly as the base block.
- Not defined: the bcast port is absent and the logic is identical to the base behaviour above.

Test Plan:
- Reset: assert rst 2 cycles during traffic -> out_valid=0x0000, y=0, acc_cnt=0; in_ready=1 after release.
- Single steer: a=0xBEEF, sel=5, in_valid 1 cycle, out_ready=0 -> next cycle out_valid=0x0020, lane 5 = 0xBEEF, acc_cnt=1, other lanes 0.
- Back-pressure: lane 5 full with out_ready[5]=0, present a=0x1234, sel=5 -> in_ready=0 and lane 5 stays 0xBEEF. Presenting sel=6 instead gives in_ready=1.
- Streaming: sel=3, out_ready[3]=1, in_valid held 8 cycles with a=0..7 -> one word per cycle on lane 3 in order 0..7, out_valid[3]=1 throughout, acc_cnt=8.
- Wrap: 65536 accepts spread over sel=0..15 with all out_ready=1 -> acc_cnt returns to 0x0000; every lane receives 4096 words in order.
- Broadcast (DEMUX16_BCAST_EN defined):
  - bcast=1, a=0xA5A5, all lanes empty -> out_valid=0xFFFF, all lanes 0xA5A5, acc_cnt=1.
  - Repeat with lane 9 full and out_ready[9]=0 -> in_ready=0, no lane changes.
